// File: rtl/vid_in_frame_burst_writer_if.sv
// Memory-side burst command and write-data channels of the frame burst writer.
// The master drives commands and data; the slave (memory port) returns the readies.
interface vid_in_frame_burst_writer_if #(
    parameter int DATA_W = 64
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [31:0]       cmd_addr;
    logic [7:0]        cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;

    modport master (
        output cmd_valid, cmd_addr, cmd_len,
        input  cmd_ready,
        output wr_valid, wr_data, wr_last,
        input  wr_ready
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len,
        output cmd_ready,
        input  wr_valid, wr_data, wr_last,
        output wr_ready
    );
endinterface

// File: rtl/vid_in_frame_burst_writer.sv
// Frame burst writer: buffers video beats, issues fixed-length write bursts, flushes residue on frame sync.
// Latency: command 1 cycle after BURST_LEN beats are buffered, data 1 cycle after command accept.
// Backpressure: cmd/wr held while ready is low; input has none, beats hitting a full FIFO are dropped.
// Build option VID_IN_FRAME_WR_DROP_STAT_EN adds the saturating dropped_cnt_o counter.

module vid_in_frame_burst_writer_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic [WIDTH-1:0] head_dat_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      count;

    assign count      = wr_ptr_q - rd_ptr_q;
    assign full_o     = (count == DEPTH_C);
    assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end
endmodule

module vid_in_frame_burst_writer #(
    parameter int DATA_W     = 64,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                        vid_in_clk_i,
    input  logic                        resetn_i,
    input  logic                        vid_in_frame_sync_i,
    input  logic [7:0]                  vid_in_frame_write_addr_i,
    input  logic                        vid_in_data_valid_i,
    input  logic [DATA_W-1:0]           vid_in_data_i,
    vid_in_frame_burst_writer_if.master mem_if,
    output logic                        frame_done_o,
`ifdef VID_IN_FRAME_WR_DROP_STAT_EN
    output logic [15:0]                 dropped_cnt_o,
`endif
    output logic                        overflow_o
);
    localparam int BYTES_PER_BEAT = DATA_W / 8;
    localparam int CW             = $clog2(FIFO_DEPTH) + 1;
    localparam int BL_M1          = BURST_LEN - 1;
    localparam logic [CW-1:0] BURST_C  = BURST_LEN[CW-1:0];
    localparam logic [7:0]    LEN_FULL = BL_M1[7:0];
    localparam logic [23:0]   BPB_C    = BYTES_PER_BEAT[23:0];

    typedef enum logic [1:0] {IDLE, CMD, DATA, SWITCH} state_e;

    state_e        state_q, state_d;
    logic [7:0]    cur_base_q, cur_base_d;
    logic [7:0]    next_base_q, next_base_d;
    logic [23:0]   offset_q, offset_d;
    logic [CW-1:0] uncmd_q, uncmd_d;
    logic [CW-1:0] flush_cnt_q, flush_cnt_d;
    logic          flush_pending_q, flush_pending_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    beat_q, beat_d;
    logic          is_flush_q, is_flush_d;
    logic          overflow_q, overflow_d;

    logic              fifo_full;
    logic [DATA_W-1:0] fifo_head;
    logic              push, drop, pop;
    logic              full_take, switch_done, violation;
    logic [CW-1:0]     flush_take, flush_len, flush_len_m1, uncmd_rem;
    logic [23:0]       burst_bytes;

    assign push = vid_in_data_valid_i & ~fifo_full;
    assign drop = vid_in_data_valid_i & fifo_full;
    assign pop  = (state_q == DATA) & mem_if.wr_ready;

    vid_in_frame_burst_writer_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (vid_in_clk_i),
        .rst_n_i    (resetn_i),
        .push_i     (push),
        .push_dat_i (vid_in_data_i),
        .pop_i      (pop),
        .full_o     (fifo_full),
        .head_dat_o (fifo_head)
    );

    // Flush bursts are capped at BURST_LEN so a deep residue still fits the 8-bit length field.
    assign flush_len    = (flush_cnt_q > BURST_C) ? BURST_C : flush_cnt_q;
    assign flush_len_m1 = flush_len - 1'b1;
    assign burst_bytes  = ({16'd0, len_q} + 24'd1) * BPB_C;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        beat_d      = beat_q;
        is_flush_d  = is_flush_q;
        cur_base_d  = cur_base_q;
        offset_d    = offset_q;
        full_take   = 1'b0;
        flush_take  = '0;
        switch_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_pending_q && (flush_cnt_q != '0)) begin
                    flush_take = flush_len;
                    len_d      = 8'(flush_len_m1);
                    beat_d     = '0;
                    is_flush_d = 1'b1;
                    state_d    = CMD;
                end else if (flush_pending_q) begin
                    state_d = SWITCH;
                end else if (uncmd_q >= BURST_C) begin
                    full_take  = 1'b1;
                    len_d      = LEN_FULL;
                    beat_d     = '0;
                    is_flush_d = 1'b0;
                    state_d    = CMD;
                end
            end
            CMD: begin
                if (mem_if.cmd_ready) begin
                    offset_d = offset_q + burst_bytes;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (pop) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q == len_q) begin
                        // Residue left over from a capped flush goes back through IDLE first.
                        state_d = (is_flush_q && (flush_cnt_q == '0)) ? SWITCH : IDLE;
                    end
                end
            end
            SWITCH: begin
                cur_base_d  = next_base_q;
                offset_d    = '0;
                switch_done = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A sync landing in SWITCH is the normal next frame, not a second unresolved sync.
    assign violation = vid_in_frame_sync_i & flush_pending_q & (state_q != SWITCH);
    assign uncmd_rem = uncmd_q - (full_take ? BURST_C : '0);

    always_comb begin
        uncmd_d         = uncmd_rem + {{(CW-1){1'b0}}, push};
        flush_cnt_d     = flush_cnt_q - flush_take;
        flush_pending_d = flush_pending_q & ~switch_done;
        next_base_d     = next_base_q;
        overflow_d      = overflow_q | drop;
        if (vid_in_frame_sync_i) begin
            uncmd_d         = {{(CW-1){1'b0}}, push};
            flush_cnt_d     = flush_cnt_q - flush_take + uncmd_rem;
            flush_pending_d = 1'b1;
            next_base_d     = vid_in_frame_write_addr_i;
            overflow_d      = violation | drop;
        end
    end

    always_ff @(posedge vid_in_clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q         <= IDLE;
            cur_base_q      <= '0;
            next_base_q     <= '0;
            offset_q        <= '0;
            uncmd_q         <= '0;
            flush_cnt_q     <= '0;
            flush_pending_q <= 1'b0;
            len_q           <= '0;
            beat_q          <= '0;
            is_flush_q      <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cur_base_q      <= cur_base_d;
            next_base_q     <= next_base_d;
            offset_q        <= offset_d;
            uncmd_q         <= uncmd_d;
            flush_cnt_q     <= flush_cnt_d;
            flush_pending_q <= flush_pending_d;
            len_q           <= len_d;
            beat_q          <= beat_d;
            is_flush_q      <= is_flush_d;
            overflow_q      <= overflow_d;
        end
    end

    assign mem_if.cmd_valid = (state_q == CMD);
    assign mem_if.cmd_addr  = {cur_base_q, offset_q};
    assign mem_if.cmd_len   = len_q;
    assign mem_if.wr_valid  = (state_q == DATA);
    assign mem_if.wr_data   = (state_q == DATA) ? fifo_head : '0;
    assign mem_if.wr_last   = (state_q == DATA) & (beat_q == len_q);
    assign frame_done_o     = (state_q == SWITCH);
    assign overflow_o       = overflow_q;

`ifdef VID_IN_FRAME_WR_DROP_STAT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge vid_in_clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign dropped_cnt_o = drop_cnt_q;
`endif
endmodule
